mem_issue_queue: RTL

Parametrised, age-ordered, collapsing issue queue for memory micro-ops, sitting between dispatch and the load/store execution ports. It accepts up to `DISPATCH_WIDTH` uops per cycle and wakes operands from a `CTB_WIDTH`-wide common tag bus. It issues up to `ISSUE_WIDTH` uops per cycle, oldest first, honouring per-port busy backpressure and store ordering. It supports a full pipeline flush.

---
 rtl/mem_issue_queue_pkg.sv | 44 ++++
 rtl/mem_issue_queue_wakeup.sv | 31 +++
 rtl/mem_issue_queue.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_issue_queue_pkg.sv
// Shared micro-op types used by the memory pipeline, plus the memory issue queue entry format.
package mem_issue_queue_pkg;

  localparam int MICRO_OP_PRF_W       = 6;
  localparam int MICRO_OP_ROB_W       = 6;
  localparam int IQ_MEM_DEPTH_DEFAULT = 16;

  typedef enum logic [0:0] {
    MEM_LD = 1'b0,
    MEM_ST = 1'b1
  } mem_type_t;

  typedef enum logic [1:0] {
    RS_FROM_RF   = 2'd0,
    RS_FROM_IMM  = 2'd1,
    RS_FROM_PC   = 2'd2,
    RS_FROM_ZERO = 2'd3
  } rs_src_t;

  typedef struct packed {
    logic                      valid;
    mem_type_t                 mem_type;
    rs_src_t                   rs1_src;
    rs_src_t                   rs2_src;
    logic [MICRO_OP_PRF_W-1:0] rs1_prf;
    logic [MICRO_OP_PRF_W-1:0] rs2_prf;
    logic                      rs1_from_ctb;
    logic                      rs2_from_ctb;
    logic [MICRO_OP_PRF_W-1:0] rd_prf;
    logic [MICRO_OP_ROB_W-1:0] rob_idx;
  } micro_op_t;

  typedef struct packed {
    micro_op_t uop;
    logic      rs1_ready;
    logic      rs2_ready;
  } mem_iq_entry_t;

  // Only register-file operands still in flight wait for a tag broadcast.
  function automatic logic operand_needs_wakeup(input rs_src_t src, input logic from_ctb);
    return (src == RS_FROM_RF) && from_ctb;
  endfunction

endpackage

// File: rtl/mem_issue_queue_wakeup.sv
// Per-entry common-tag-bus matcher: ORs any valid tag hit into sticky operand ready bits.
module mem_iq_wakeup #(
  parameter int CTB_WIDTH   = 4,
  parameter int PRF_INDEX_W = 6
) (
  input  logic [PRF_INDEX_W-1:0]                rs1_prf,
  input  logic [PRF_INDEX_W-1:0]                rs2_prf,
  input  logic                                  rs1_ready_in,
  input  logic                                  rs2_ready_in,
  input  logic [CTB_WIDTH-1:0][PRF_INDEX_W-1:0] ctb_prf_index,
  input  logic [CTB_WIDTH-1:0]                  ctb_valid,
  output logic                                  rs1_ready_out,
  output logic                                  rs2_ready_out
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int i = 0; i < CTB_WIDTH; i++) begin
      if (ctb_valid[i] && (ctb_prf_index[i] == rs1_prf)) rs1_hit = 1'b1;
      if (ctb_valid[i] && (ctb_prf_index[i] == rs2_prf)) rs2_hit = 1'b1;
    end
  end

  assign rs1_ready_out = rs1_ready_in | rs1_hit;
  assign rs2_ready_out = rs2_ready_in | rs2_hit;

endmodule

// File: rtl/mem_issue_queue.sv
// Age-ordered collapsing issue queue for memory uops; slot 0 is always the oldest entry.
// Define MEM_IQ_LOAD_ORDER_EN to hold loads behind any older resident store.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int DEPTH          = IQ_MEM_DEPTH_DEFAULT,
  parameter int DISPATCH_WIDTH = 4,
  parameter int ISSUE_WIDTH    = 2,
  parameter int CTB_WIDTH      = 4,
  parameter int PRF_INDEX_W    = MICRO_OP_PRF_W
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [CTB_WIDTH-1:0][PRF_INDEX_W-1:0] ctb_prf_index,
  input  logic [CTB_WIDTH-1:0]                  ctb_valid,
  input  logic [ISSUE_WIDTH-1:0]                ex_busy,
  input  micro_op_t [DISPATCH_WIDTH-1:0]        uop_in,
  output micro_op_t [ISSUE_WIDTH-1:0]           uop_out,
  output logic                                  iq_full,
  output logic [$clog2(DEPTH+1)-1:0]            count
);

  localparam int CNT_W = $clog2(DEPTH+1);

  mem_iq_entry_t             slot_q [DEPTH];
  mem_iq_entry_t             slot_d [DEPTH];
  logic [CNT_W-1:0]          count_q;
  logic [CNT_W-1:0]          count_d;
  logic [DEPTH-1:0]          woken_rs1;
  logic [DEPTH-1:0]          woken_rs2;
  logic [DISPATCH_WIDTH-1:0] in_rs1_ready;
  logic [DISPATCH_WIDTH-1:0] in_rs2_ready;
  logic [DEPTH-1:0]          slot_eligible;
  logic [DEPTH-1:0]          issue_mask;
  logic                      insert_en;

  // Full only looks at the registered count, so space for a whole dispatch group is guaranteed.
  assign iq_full   = (count_q > CNT_W'(DEPTH - DISPATCH_WIDTH));
  assign insert_en = !iq_full && !flush;
  assign count     = count_q;

  for (genvar s = 0; s < DEPTH; s++) begin : g_slot_wakeup
    mem_iq_wakeup #(
      .CTB_WIDTH   (CTB_WIDTH),
      .PRF_INDEX_W (PRF_INDEX_W)
    ) u_wakeup (
      .rs1_prf       (slot_q[s].uop.rs1_prf),
      .rs2_prf       (slot_q[s].uop.rs2_prf),
      .rs1_ready_in  (slot_q[s].rs1_ready),
      .rs2_ready_in  (slot_q[s].rs2_ready),
      .ctb_prf_index (ctb_prf_index),
      .ctb_valid     (ctb_valid),
      .rs1_ready_out (woken_rs1[s]),
      .rs2_ready_out (woken_rs2[s])
    );
  end

  for (genvar l = 0; l < DISPATCH_WIDTH; l++) begin : g_inbound_wakeup
    mem_iq_wakeup #(
      .CTB_WIDTH   (CTB_WIDTH),
      .PRF_INDEX_W (PRF_INDEX_W)
    ) u_wakeup (
      .rs1_prf       (uop_in[l].rs1_prf),
      .rs2_prf       (uop_in[l].rs2_prf),
      .rs1_ready_in  (!operand_needs_wakeup(uop_in[l].rs1_src, uop_in[l].rs1_from_ctb)),
      .rs2_ready_in  (!operand_needs_wakeup(uop_in[l].rs2_src, uop_in[l].rs2_from_ctb)),
      .ctb_prf_index (ctb_prf_index),
      .ctb_valid     (ctb_valid),
      .rs1_ready_out (in_rs1_ready[l]),
      .rs2_ready_out (in_rs2_ready[l])
    );
  end

  always_comb begin
`ifdef MEM_IQ_LOAD_ORDER_EN
    logic older_store;
    older_store = 1'b0;
`endif
    slot_eligible = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if (slot_q[s].uop.mem_type == MEM_ST) begin
        slot_eligible[s] = slot_q[s].uop.valid && slot_q[s].rs1_ready &&
                           slot_q[s].rs2_ready && (s == 0);
      end else begin
`ifdef MEM_IQ_LOAD_ORDER_EN
        slot_eligible[s] = slot_q[s].uop.valid && slot_q[s].rs1_ready &&
                           slot_q[s].rs2_ready && !older_store;
`else
        slot_eligible[s] = slot_q[s].uop.valid && slot_q[s].rs1_ready &&
                           slot_q[s].rs2_ready;
`endif
      end
`ifdef MEM_IQ_LOAD_ORDER_EN
      if (slot_q[s].uop.valid && (slot_q[s].uop.mem_type == MEM_ST)) older_store = 1'b1;
`endif
    end
  end

  // Each free port, in ascending order, takes the oldest eligible slot not already picked.
  always_comb begin
    logic found;
    issue_mask = '0;
    found      = 1'b0;
    for (int p = 0; p < ISSUE_WIDTH; p++) begin
      uop_out[p] = '0;
      found      = 1'b0;
      if (!reset && !flush && !ex_busy[p]) begin
        for (int s = 0; s < DEPTH; s++) begin
          if (!found && slot_eligible[s] && !issue_mask[s]) begin
            found         = 1'b1;
            issue_mask[s] = 1'b1;
            uop_out[p]    = slot_q[s].uop;
          end
        end
      end
    end
  end

  always_comb begin
    logic [CNT_W-1:0] surv_pos [DEPTH];
    logic [CNT_W-1:0] in_pos [DISPATCH_WIDTH];
    logic [CNT_W-1:0] n_surv;
    logic [CNT_W-1:0] n_issued;
    logic [CNT_W-1:0] n_inserted;
    n_surv     = '0;
    n_issued   = '0;
    n_inserted = '0;
    for (int s = 0; s < DEPTH; s++) begin
      surv_pos[s] = n_surv;
      if (slot_q[s].uop.valid && !issue_mask[s]) n_surv = n_surv + CNT_W'(1);
      if (issue_mask[s]) n_issued = n_issued + CNT_W'(1);
    end
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      in_pos[l] = n_surv + n_inserted;
      if (insert_en && uop_in[l].valid) n_inserted = n_inserted + CNT_W'(1);
    end
    for (int d = 0; d < DEPTH; d++) begin
      slot_d[d] = '0;
      for (int s = 0; s < DEPTH; s++) begin
        if (slot_q[s].uop.valid && !issue_mask[s] && (surv_pos[s] == CNT_W'(d))) begin
          slot_d[d].uop       = slot_q[s].uop;
          slot_d[d].rs1_ready = woken_rs1[s];
          slot_d[d].rs2_ready = woken_rs2[s];
        end
      end
      for (int l = 0; l < DISPATCH_WIDTH; l++) begin
        if (insert_en && uop_in[l].valid && (in_pos[l] == CNT_W'(d))) begin
          slot_d[d].uop       = uop_in[l];
          slot_d[d].rs1_ready = in_rs1_ready[l];
          slot_d[d].rs2_ready = in_rs2_ready[l];
        end
      end
      if (flush) slot_d[d] = '0;
    end
    count_d = count_q - n_issued + n_inserted;
    if (flush) count_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) slot_q[s] <= '0;
      count_q <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) slot_q[s] <= slot_d[s];
      count_q <= count_d;
    end
  end

endmodule
